// File: rtl/ibex_pmu_counter_mo.sv
// PMU counter-interface unit: multi-outstanding PMC_REQ issue with an in-order we-queue,
// serialised WFP/WFO waits. Optional WFX watchdog enabled by `IBEX_PMU_WFX_TIMEOUT_EN.

package ibex_pmu_counter_mo_pkg;

    typedef enum logic [1:0] {
        PMC_IDLE = 2'd0,
        PMC_REQ  = 2'd1,
        PMC_WFP  = 2'd2,
        PMC_WFO  = 2'd3
    } pmc_op_e;

endpackage

module ibex_pmu_counter_mo
    import ibex_pmu_counter_mo_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    output pmc_op_e     counter_op_o,
    input  logic        counter_gnt_i,
    input  logic        counter_rvalid_i,
    input  logic        counter_err_i,
    output logic [31:0] counter_addr_o,
    output logic        counter_we_o,
    output logic [31:0] counter_wdata_o,
    input  logic [31:0] counter_rdata_i,

    input  logic        pmc_req_i,
    input  pmc_op_e     pmc_op_i,
    input  logic        pmc_we_i,
    input  logic [31:0] pmc_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic [31:0] pmc_rdata_o,
    output logic        pmc_rdata_valid_o,
    output logic        pmc_resp_valid_o,
    output logic        pmc_err_o,
    output logic        pmc_timeout_o,
    output logic        pmc_busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    if (MaxOutstanding < 1 || MaxOutstanding > 8 || TimeoutCycles < 2) begin : g_param_check
        $error("ibex_pmu_counter_mo: illegal MaxOutstanding or TimeoutCycles");
    end

    typedef enum logic {
        IDLE = 1'b0,
        WFX  = 1'b1
    } state_e;

    state_e                    state_q;
    logic [CntW-1:0]           cnt_q;
    logic [PtrW-1:0]           head_q;
    logic [PtrW-1:0]           tail_q;
    logic [MaxOutstanding-1:0] we_q;
    pmc_op_e                   wfx_op_q;

    logic push;
    logic pop;
    logic wfx_enter;
    logic wfx_exit;
    logic timeout_c;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign counter_addr_o  = adder_result_ex_i;
    assign counter_we_o    = pmc_we_i;
    assign counter_wdata_o = pmc_wdata_i;
    assign pmc_rdata_o     = counter_rdata_i;
    assign pmc_timeout_o   = timeout_c;

`ifdef IBEX_PMU_WFX_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles);

    logic [TmoW-1:0] tmo_cnt_q;
    logic            tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TmoW'(TimeoutCycles - 1));

    // Counts WFX cycles without a response; restarts on every WFX entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (wfx_enter) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WFX && !wfx_exit) begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
        end
    end
`endif

    // Issue, response and busy decode; all combinational from state and bus inputs.
    always_comb begin
        counter_op_o      = PMC_IDLE;
        pmc_rdata_valid_o = 1'b0;
        pmc_resp_valid_o  = 1'b0;
        pmc_err_o         = 1'b0;
        pmc_busy_o        = 1'b0;
        timeout_c         = 1'b0;
        push              = 1'b0;
        pop               = 1'b0;
        wfx_enter         = 1'b0;
        wfx_exit          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pmc_req_i) begin
                    if (pmc_op_i == PMC_REQ) begin
                        if (counter_gnt_i && (cnt_q < CntW'(MaxOutstanding))) begin
                            counter_op_o = PMC_REQ;
                            push         = 1'b1;
                        end else begin
                            pmc_busy_o = 1'b1;
                        end
                    end else if (pmc_op_i != PMC_IDLE && counter_gnt_i && cnt_q == '0) begin
                        counter_op_o = pmc_op_i;
                        wfx_enter    = 1'b1;
                    end else begin
                        // Wait ops drain all outstanding requests before issuing.
                        pmc_busy_o = 1'b1;
                    end
                end
                if (counter_rvalid_i && cnt_q != '0) begin
                    pop               = 1'b1;
                    pmc_resp_valid_o  = 1'b1;
                    pmc_rdata_valid_o = ~we_q[head_q] & ~counter_err_i;
                    pmc_err_o         = counter_err_i;
                end
            end
            WFX: begin
                pmc_busy_o   = 1'b1;
                counter_op_o = wfx_op_q;
                if (counter_rvalid_i) begin
                    pmc_resp_valid_o  = 1'b1;
                    pmc_rdata_valid_o = ~counter_err_i;
                    pmc_err_o         = counter_err_i;
                    counter_op_o      = PMC_IDLE;
                    wfx_exit          = 1'b1;
`ifdef IBEX_PMU_WFX_TIMEOUT_EN
                end else if (tmo_hit) begin
                    pmc_resp_valid_o = 1'b1;
                    timeout_c        = 1'b1;
                    counter_op_o     = PMC_IDLE;
                    wfx_exit         = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    // FSM, outstanding count and in-order we-queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            we_q     <= '0;
            wfx_op_q <= PMC_IDLE;
        end else begin
            if (push) begin
                we_q[tail_q] <= pmc_we_i;
                tail_q       <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
            if (wfx_enter) begin
                state_q  <= WFX;
                wfx_op_q <= pmc_op_i;
            end else if (wfx_exit) begin
                state_q <= IDLE;
            end
        end
    end

endmodule
